// File: rtl/morse_encoder.sv
// Morse character encoder: one ASCII character per handshake, keyed out as timed marks/spaces
// with a parallel DIT/DAH/GAP/SPACE strobe stream. Optional MORSE_LOWERCASE_EN accepts a-z as A-Z.
module morse_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] letter,
    input  logic       letter_valid,
    output logic       letter_ready,
    output logic       key,
    output logic [2:0] symbol,
    output logic       busy,
    output logic       err
);

    // Sized for the word gap (4 units), the longest single state.
    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] C_1U = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_3U = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_4U = CW'(4 * UNIT_CYCLES - 1);

    localparam logic [2:0] SYM_WAIT  = 3'd0;
    localparam logic [2:0] SYM_DIT   = 3'd1;
    localparam logic [2:0] SYM_DAH   = 3'd2;
    localparam logic [2:0] SYM_GAP   = 3'd3;
    localparam logic [2:0] SYM_SPACE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_ELEM_GAP,
        S_LETTER_GAP,
        S_WORD_GAP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_pat;
    logic [2:0]    r_left;
    logic          r_key;
    logic [2:0]    r_symbol;
    logic          r_err;

    logic       w_is_alpha;
    logic [4:0] w_idx;
    logic [2:0] w_len;
    logic [3:0] w_pat;

    // Code table: length plus left-aligned pattern, 1 = dah, sent MSB first.
    always_comb begin
        w_is_alpha = (letter >= 8'd65) && (letter <= 8'd90);
        w_idx      = 5'(letter - 8'd65);
`ifdef MORSE_LOWERCASE_EN
        if ((letter >= 8'd97) && (letter <= 8'd122)) begin
            w_is_alpha = 1'b1;
            w_idx      = 5'(letter - 8'd97);
        end
`endif
        case (w_idx)
            5'd0:    {w_len, w_pat} = {3'd2, 4'b0100}; // A .-
            5'd1:    {w_len, w_pat} = {3'd4, 4'b1000}; // B -...
            5'd2:    {w_len, w_pat} = {3'd4, 4'b1010}; // C -.-.
            5'd3:    {w_len, w_pat} = {3'd3, 4'b1000}; // D -..
            5'd4:    {w_len, w_pat} = {3'd1, 4'b0000}; // E .
            5'd5:    {w_len, w_pat} = {3'd4, 4'b0010}; // F ..-.
            5'd6:    {w_len, w_pat} = {3'd3, 4'b1100}; // G --.
            5'd7:    {w_len, w_pat} = {3'd4, 4'b0000}; // H ....
            5'd8:    {w_len, w_pat} = {3'd2, 4'b0000}; // I ..
            5'd9:    {w_len, w_pat} = {3'd4, 4'b0111}; // J .---
            5'd10:   {w_len, w_pat} = {3'd3, 4'b1010}; // K -.-
            5'd11:   {w_len, w_pat} = {3'd4, 4'b0100}; // L .-..
            5'd12:   {w_len, w_pat} = {3'd2, 4'b1100}; // M --
            5'd13:   {w_len, w_pat} = {3'd2, 4'b1000}; // N -.
            5'd14:   {w_len, w_pat} = {3'd3, 4'b1110}; // O ---
            5'd15:   {w_len, w_pat} = {3'd4, 4'b0110}; // P .--.
            5'd16:   {w_len, w_pat} = {3'd4, 4'b1101}; // Q --.-
            5'd17:   {w_len, w_pat} = {3'd3, 4'b0100}; // R .-.
            5'd18:   {w_len, w_pat} = {3'd3, 4'b0000}; // S ...
            5'd19:   {w_len, w_pat} = {3'd1, 4'b1000}; // T -
            5'd20:   {w_len, w_pat} = {3'd3, 4'b0010}; // U ..-
            5'd21:   {w_len, w_pat} = {3'd4, 4'b0001}; // V ...-
            5'd22:   {w_len, w_pat} = {3'd3, 4'b0110}; // W .--
            5'd23:   {w_len, w_pat} = {3'd4, 4'b1001}; // X -..-
            5'd24:   {w_len, w_pat} = {3'd4, 4'b1011}; // Y -.--
            5'd25:   {w_len, w_pat} = {3'd4, 4'b1100}; // Z --..
            default: {w_len, w_pat} = {3'd0, 4'b0000};
        endcase
    end

    // r_pat holds the elements still to send (current one already consumed), r_left their count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pat    <= '0;
            r_left   <= '0;
            r_key    <= 1'b0;
            r_symbol <= SYM_WAIT;
            r_err    <= 1'b0;
        end else begin
            r_symbol <= SYM_WAIT;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (letter_valid) begin
                        if (w_is_alpha) begin
                            r_state  <= S_MARK;
                            r_pat    <= {w_pat[2:0], 1'b0};
                            r_left   <= w_len - 3'd1;
                            r_key    <= 1'b1;
                            r_symbol <= w_pat[3] ? SYM_DAH : SYM_DIT;
                            r_cnt    <= w_pat[3] ? C_3U : C_1U;
                        end else if (letter == 8'd32) begin
                            r_state  <= S_WORD_GAP;
                            r_symbol <= SYM_SPACE;
                            r_cnt    <= C_4U;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_MARK: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_left != 3'd0) begin
                        r_state <= S_ELEM_GAP;
                        r_key   <= 1'b0;
                        r_cnt   <= C_1U;
                    end else begin
                        r_state  <= S_LETTER_GAP;
                        r_key    <= 1'b0;
                        r_symbol <= SYM_GAP;
                        r_cnt    <= C_3U;
                    end
                end
                S_ELEM_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state  <= S_MARK;
                        r_key    <= 1'b1;
                        r_symbol <= r_pat[3] ? SYM_DAH : SYM_DIT;
                        r_cnt    <= r_pat[3] ? C_3U : C_1U;
                        r_pat    <= {r_pat[2:0], 1'b0};
                        r_left   <= r_left - 3'd1;
                    end
                end
                S_LETTER_GAP, S_WORD_GAP: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else             r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign letter_ready = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign key          = r_key;
    assign symbol       = r_symbol;
    assign err          = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: U=4 instance for timing/handshake/reset, U=1 instance for 'Y'.
module tb_morse_encoder;

    localparam logic [2:0] SW  = 3'd0;
    localparam logic [2:0] DIT = 3'd1;
    localparam logic [2:0] DAH = 3'd2;
    localparam logic [2:0] GAP = 3'd3;
    localparam logic [2:0] SPC = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] letter4, letter1;
    logic       valid4, valid1;
    logic       ready4, key4, busy4, err4;
    logic       ready1, key1, busy1, err1;
    logic [2:0] sym4, sym1;

    int tests = 0;
    int fails = 0;

    morse_encoder #(.UNIT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .letter(letter4), .letter_valid(valid4),
        .letter_ready(ready4), .key(key4), .symbol(sym4), .busy(busy4), .err(err4)
    );

    morse_encoder #(.UNIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .letter(letter1), .letter_valid(valid1),
        .letter_ready(ready1), .key(key1), .symbol(sym1), .busy(busy1), .err(err1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n busy cycles with constant key; strobe s0 only in the first cycle.
    task automatic run(input bit u1, input string tag, input logic k, input int n, input logic [2:0] s0);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s key c%0d", tag, i), 8'(u1 ? key1 : key4), 8'(k));
            check($sformatf("%s sym c%0d", tag, i), 8'(u1 ? sym1 : sym4), 8'((i == 0) ? s0 : SW));
            check($sformatf("%s rdy c%0d", tag, i), 8'(u1 ? ready1 : ready4), 8'd0);
            check($sformatf("%s busy c%0d", tag, i), 8'(u1 ? busy1 : busy4), 8'd1);
            step();
        end
    endtask

    task automatic idle_chk(input string tag);
        check({tag, " ready"}, 8'(ready4), 8'd1);
        check({tag, " busy"}, 8'(busy4), 8'd0);
        check({tag, " key"}, 8'(key4), 8'd0);
    endtask

    initial begin
        reset = 1'b1; letter4 = 8'd0; valid4 = 1'b0; letter1 = 8'd0; valid1 = 1'b0;
        #12;
        check("rst key", 8'(key4), 8'd0);
        check("rst sym", 8'(sym4), 8'd0);
        check("rst err", 8'(err4), 8'd0);
        check("rst busy", 8'(busy4), 8'd0);
        check("rst ready", 8'(ready4), 8'd1);
        check("rst ready1", 8'(ready1), 8'd1);
        step();
        reset = 1'b0;
        step();
        idle_chk("post rst");

        // 'E': single dit, letter gap, ready at t0+16
        letter4 = "E"; valid4 = 1'b1; step(); valid4 = 1'b0;
        run(0, "E dit", 1'b1, 4, DIT);
        run(0, "E lgap", 1'b0, 12, GAP);
        idle_chk("E done");

        // 'A': .-
        letter4 = "A"; valid4 = 1'b1; step(); valid4 = 1'b0;
        run(0, "A dit", 1'b1, 4, DIT);
        run(0, "A egap", 1'b0, 4, SW);
        run(0, "A dah", 1'b1, 12, DAH);
        run(0, "A lgap", 1'b0, 12, GAP);
        idle_chk("A done");

        // 'Q' then ' ' with valid held through busy
        letter4 = "Q"; valid4 = 1'b1; step(); letter4 = " ";
        run(0, "Q dah0", 1'b1, 12, DAH);
        run(0, "Q eg0", 1'b0, 4, SW);
        run(0, "Q dah1", 1'b1, 12, DAH);
        run(0, "Q eg1", 1'b0, 4, SW);
        run(0, "Q dit2", 1'b1, 4, DIT);
        run(0, "Q eg2", 1'b0, 4, SW);
        run(0, "Q dah3", 1'b1, 12, DAH);
        run(0, "Q lgap", 1'b0, 12, GAP);
        idle_chk("Q done");
        step(); valid4 = 1'b0;
        run(0, "space", 1'b0, 16, SPC);
        idle_chk("space done");

        // unsupported '7'
        letter4 = "7"; valid4 = 1'b1; step(); valid4 = 1'b0;
        check("7 err", 8'(err4), 8'd1);
        check("7 sym", 8'(sym4), 8'(SW));
        idle_chk("7");
        step();
        check("7 err clr", 8'(err4), 8'd0);

        // lowercase 'q'
        letter4 = "q"; valid4 = 1'b1; step(); valid4 = 1'b0;
`ifdef MORSE_LOWERCASE_EN
        check("q err", 8'(err4), 8'd0);
        run(0, "q dah0", 1'b1, 12, DAH);
        run(0, "q eg0", 1'b0, 4, SW);
        run(0, "q dah1", 1'b1, 12, DAH);
        run(0, "q eg1", 1'b0, 4, SW);
        run(0, "q dit2", 1'b1, 4, DIT);
        run(0, "q eg2", 1'b0, 4, SW);
        run(0, "q dah3", 1'b1, 12, DAH);
        run(0, "q lgap", 1'b0, 12, GAP);
        idle_chk("q done");
`else
        check("q err", 8'(err4), 8'd1);
        check("q sym", 8'(sym4), 8'(SW));
        idle_chk("q");
        step();
        check("q err clr", 8'(err4), 8'd0);
`endif

        // S,O,S with valid held high and letter changing while busy
        letter4 = "S"; valid4 = 1'b1; step(); letter4 = "O";
        run(0, "S1 d0", 1'b1, 4, DIT);
        run(0, "S1 g0", 1'b0, 4, SW);
        run(0, "S1 d1", 1'b1, 4, DIT);
        run(0, "S1 g1", 1'b0, 4, SW);
        run(0, "S1 d2", 1'b1, 4, DIT);
        run(0, "S1 lgap", 1'b0, 12, GAP);
        idle_chk("S1 done");
        step(); letter4 = "S";
        run(0, "O d0", 1'b1, 12, DAH);
        run(0, "O g0", 1'b0, 4, SW);
        run(0, "O d1", 1'b1, 12, DAH);
        run(0, "O g1", 1'b0, 4, SW);
        run(0, "O d2", 1'b1, 12, DAH);
        run(0, "O lgap", 1'b0, 12, GAP);
        idle_chk("O done");
        step(); valid4 = 1'b0;
        run(0, "S2 d0", 1'b1, 4, DIT);
        run(0, "S2 g0", 1'b0, 4, SW);
        run(0, "S2 d1", 1'b1, 4, DIT);
        run(0, "S2 g1", 1'b0, 4, SW);
        run(0, "S2 d2", 1'b1, 4, DIT);
        run(0, "S2 lgap", 1'b0, 12, GAP);
        idle_chk("SOS done");
        step(); step();
        idle_chk("SOS no 4th");

        // reset mid-dah of 'T'
        letter4 = "T"; valid4 = 1'b1; step(); valid4 = 1'b0;
        run(0, "T dah", 1'b1, 6, DAH);
        #2 reset = 1'b1;
        #1;
        check("T rst sym", 8'(sym4), 8'(SW));
        idle_chk("T rst");
        step();
        reset = 1'b0;
        step();
        letter4 = "E"; valid4 = 1'b1; step(); valid4 = 1'b0;
        run(0, "E2 dit", 1'b1, 4, DIT);
        run(0, "E2 lgap", 1'b0, 12, GAP);
        idle_chk("E2 done");

        // U=1 'Y' -.--
        letter1 = "Y"; valid1 = 1'b1; step(); valid1 = 1'b0;
        run(1, "Y dah0", 1'b1, 3, DAH);
        run(1, "Y eg0", 1'b0, 1, SW);
        run(1, "Y dit1", 1'b1, 1, DIT);
        run(1, "Y eg1", 1'b0, 1, SW);
        run(1, "Y dah2", 1'b1, 3, DAH);
        run(1, "Y eg2", 1'b0, 1, SW);
        run(1, "Y dah3", 1'b1, 3, DAH);
        run(1, "Y lgap", 1'b0, 3, GAP);
        check("Y ready", 8'(ready1), 8'd1);
        check("Y busy", 8'(busy1), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
